hilo_div_unit: RTL
==================

Name: hilo_div_unit

Overview:
- Multi-cycle integer divider that executes the pipeline's `div`/`divu` and writes the HI/LO pair.
- It is the responder to the ID/EX stage's divide request: the pipeline issues operands and a start pulse, and this block returns remainder (HI) and quotient (LO).
- It raises busy so the hazard unit stalls `mfhi`/`mflo` until results are valid.
- The radix-2 restoring algorithm runs on magnitudes, followed by a sign-fixup cycle.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  divide request; sampled only in IDLE
- is_signed  in  1  1 = `div` (two's complement), 0 = `divu`; captured with start
- dividend  in  WIDTH  rs operand; captured with start
- divisor  in  WIDTH  rt operand; captured with start
- flush  in  1  pipeline flush; cancels an in-flight divide
- busy  out  1  operation in progress (RUN or FIXUP)
- done  out  1  one-cycle pulse; also serves as HI/LO write enable
- hi  out  WIDTH  remainder register
- lo  out  WIDTH  quotient register
- div_by_zero  out  1  sticky flag for the last completed op; valid from done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, internal counter and shift registers cleared. Deassertion is synchronised externally.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - On an edge with start=1, capture is_signed, the operand signs, |dividend|, |divisor| (magnitudes when signed, raw values when unsigned), and divisor==0.
  - Clear the partial remainder, set counter=0, go to RUN; busy=1 from this edge.
  - start=0: hold; hi/lo keep their last values.
- RUN:
  - One restoring step per edge: shift {rem,quo} left 1, trial-subtract the divisor magnitude, keep the result if non-negative, set the quotient bit.
  - counter increments; after WIDTH steps (counter==WIDTH-1 on that edge) go to FIXUP.
- FIXUP:
  - If the signed quotient signs differ, negate the quotient; if the dividend was negative, negate the remainder.
  - If divisor==0, force lo={WIDTH{1}}, hi=original dividend, div_by_zero=1; otherwise div_by_zero=0.
  - Write hi/lo, busy=0, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE. start in DONE is ignored and must be re-presented in IDLE.
- Latency: with start accepted at edge E0, results and done appear after edge E0+WIDTH+1 (E33 for WIDTH=32), and done drops at E0+WIDTH+2. Latency is identical for all operands, including divide-by-zero.
- Arithmetic:
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0, div_by_zero=0, with no trap.
- Start while busy: ignored, with no effect on the in-flight op. The hazard unit guarantees this does not happen, but the block must tolerate it.
- Flush:
  - In RUN or FIXUP: return to IDLE on the next edge, busy=0, no done, hi/lo/div_by_zero unchanged.
  - In DONE: done still completes, because results were already written at the FIXUP edge.
  - In IDLE, flush and start on the same edge: flush wins and start is dropped.
- Reset mid-operation: immediate return to the reset values; no done.
- Outputs hi/lo/div_by_zero are registered, and stable between done pulses.

Test Plan:
- Unsigned 7 / 2 (is_signed=0), start at E0: busy high E0..E33, done pulse after E33, lo=0x00000003, hi=0x00000001, div_by_zero=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then signed 7 / -2: lo=0xFFFFFFFD, hi=0x00000001.
- Divide-by-zero 0x0000001C / 0, signed and unsigned: done at the same latency, lo=0xFFFFFFFF, hi=0x0000001C, div_by_zero=1. A following 10/3 clears the flag (lo=3, hi=1).
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Unsigned 0xFFFFFFFF / 0x00000010: lo=0x0FFFFFFF, hi=0x0000000F.
- Concurrency:
  - Start 100/7, re-pulse start with 5/5 at E10: the first result stands (lo=14, hi=2).
  - Flush at E20: busy drops at E21, no done, hi/lo keep their prior values.
- Reset mid-op: rst_n=0 at E15 → asynchronously busy=0, hi=lo=0, state IDLE; after release, a new 9/4 yields lo=2, hi=1.

Source files
------------

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle radix-2 restoring divider for div/divu.
// Works on operand magnitudes for WIDTH cycles, then applies the sign fixup
// and writes HI (remainder) and LO (quotient) in one further cycle.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             divide request, accepted only in IDLE
//   is_signed         1 = div (two's complement), 0 = divu
//   dividend, divisor operands, captured with start
//   flush             cancels an in-flight divide (RUN/FIXUP)
//   busy              operation in progress (RUN or FIXUP)
//   done              one-cycle pulse after results are written (HI/LO write enable)
//   hi, lo            remainder / quotient registers
//   div_by_zero       last completed op had a zero divisor
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFixup = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_q, dvs_d;      // divisor magnitude
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;    // captured divisor == 0
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    // Operand magnitudes at capture time
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // Restoring step datapath
    logic [WIDTH:0]     shifted_rem;
    logic [WIDTH:0]     trial;

    // Sign-corrected results
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        neg_a = is_signed & dividend[WIDTH-1];
        neg_b = is_signed & divisor[WIDTH-1];
        mag_a = neg_a ? (~dividend + 1'b1) : dividend;
        mag_b = neg_b ? (~divisor + 1'b1) : divisor;
    end

    // rem_q < dvs_q holds at every step, so the (WIDTH+1)-bit difference is
    // negative exactly when its top bit is set.
    always_comb begin
        shifted_rem = {rem_q, quo_q[WIDTH-1]};
        trial       = shifted_rem - {1'b0, dvs_q};
    end

    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            StIdle: begin
                // flush on the same edge drops the request
                if (start && !flush) begin
                    rem_d     = '0;
                    quo_d     = mag_a;
                    dvs_d     = mag_b;
                    neg_quo_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    zero_d    = (divisor == '0);
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted_rem[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StFixup;
                    end
                end
            end
            StFixup: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (zero_q) begin
                        // With a zero divisor every trial succeeds, so rem_q is
                        // |dividend| and rem_fix restores the original dividend.
                        lo_d  = '1;
                        hi_d  = rem_fix;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = quo_fix;
                        hi_d  = rem_fix;
                        dbz_d = 1'b0;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                // Results are already committed; start here is ignored.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        busy        = (state_q == StRun) || (state_q == StFixup);
        done        = (state_q == StDone);
        hi          = hi_q;
        lo          = lo_q;
        div_by_zero = dbz_q;
    end

endmodule
